rstgen_mod: RTL and testbench

RSTGEN_MOD -- requirements
Module: rstgen_mod

---
 rtl/rstgen_pkg.sv | 29 ++
 rtl/rst_sync.sv | 26 ++
 rtl/rstgen_mod.sv | 123 ++++++++++++
 tb/tb_rstgen_mod.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rstgen_pkg.sv
// Shared definitions for the reset generator: MCUSR layout, default I/O address
// and the RUN/HOLD state encoding.
package rstgen_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } rst_state_e;

  localparam logic [5:0] MCUSR_ADDR_DEFAULT = 6'h34;

  localparam int PORF_BIT  = 0;
  localparam int EXTRF_BIT = 1;
  localparam int WDRF_BIT  = 3;

  localparam logic [7:0] MCUSR_POR_VALUE = 8'h01;

  // Unimplemented MCUSR bits always read back as zero.
  function automatic logic [7:0] mcusr_image(input logic porf, input logic extrf,
                                             input logic wdrf);
    logic [7:0] img;
    img            = 8'h00;
    img[PORF_BIT]  = porf;
    img[EXTRF_BIT] = extrf;
    img[WDRF_BIT]  = wdrf;
    return img;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop synchronizer for the asynchronous external reset pin; both flops
// reset to 1 so the pin reads as inactive right after a system reset.
module rst_sync (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  // Synchronizer flop chain
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/rstgen_mod.sv
// Reset generator: stretches external-pin, watchdog and system resets into a
// minimum-length core reset pulse and records the cause in MCUSR.
module rstgen_mod
  import rstgen_pkg::*;
#(
  parameter logic [5:0] MCUSR_Address   = MCUSR_ADDR_DEFAULT,
  parameter int         RST_HOLD_CYCLES = 16
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] adr,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  input  logic       iore,
  input  logic       iowe,
  output logic       out_en,
  input  logic       ext_rst_n,
  input  logic       wdtmout,
  output logic       core_rst_n,
  output logic       rst_busy
);

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);

  rst_state_e state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic       porf_q, porf_d;
  logic       extrf_q, extrf_d;
  logic       wdrf_q, wdrf_d;
  logic       core_rst_n_q, core_rst_n_d;
  logic       rst_busy_q, rst_busy_d;
  logic       ext_sync;
  logic       wr_s;
  logic       unused_dbus_s;

  rst_sync u_rst_sync (
    .clk_i  (cp2),
    .srst_i (ireset),
    .d_i    (ext_rst_n),
    .q_o    (ext_sync)
  );

  assign wr_s          = (adr == MCUSR_Address) && iowe;
  assign unused_dbus_s = ^{dbus_in[7:4], dbus_in[2]};

  // Next-state, hold counter and flag update; set events override a clearing write
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    porf_d  = porf_q;
    extrf_d = extrf_q;
    wdrf_d  = wdrf_q;
    case (state_q)
      ST_RUN: begin
        if (wr_s) begin
          porf_d  = porf_q  & dbus_in[PORF_BIT];
          extrf_d = extrf_q & dbus_in[EXTRF_BIT];
          wdrf_d  = wdrf_q  & dbus_in[WDRF_BIT];
        end else begin
          porf_d = porf_q;
        end
        if (!ext_sync || wdtmout) begin
          state_d = ST_HOLD;
          hcnt_d  = 8'd0;
          if (!ext_sync) begin
            extrf_d = 1'b1;
          end else begin
            extrf_d = extrf_d;
          end
          if (wdtmout) begin
            wdrf_d = 1'b1;
          end else begin
            wdrf_d = wdrf_d;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (!ext_sync) begin
          hcnt_d = 8'd0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        hcnt_d  = 8'd0;
      end
    endcase
    core_rst_n_d = (state_d == ST_RUN);
    rst_busy_d   = (state_d == ST_HOLD);
  end

  // State, counter, flag and output registers
  always_ff @(posedge cp2) begin
    if (ireset) begin
      state_q      <= ST_HOLD;
      hcnt_q       <= 8'd0;
      porf_q       <= MCUSR_POR_VALUE[PORF_BIT];
      extrf_q      <= MCUSR_POR_VALUE[EXTRF_BIT];
      wdrf_q       <= MCUSR_POR_VALUE[WDRF_BIT];
      core_rst_n_q <= 1'b0;
      rst_busy_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      porf_q       <= porf_d;
      extrf_q      <= extrf_d;
      wdrf_q       <= wdrf_d;
      core_rst_n_q <= core_rst_n_d;
      rst_busy_q   <= rst_busy_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign rst_busy   = rst_busy_q;
  assign dbus_out   = mcusr_image(porf_q, extrf_q, wdrf_q);
  assign out_en     = (adr == MCUSR_Address) && iore;

endmodule

// File: tb/tb_rstgen_mod.sv
// Scenario bench for rstgen_mod: expected core reset levels and MCUSR images are
// queued as stimulus is driven and checked after each clock edge.
module tb_rstgen_mod;

  localparam int         HOLD = 16;
  localparam logic [5:0] ADDR = 6'h34;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] adr;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       iore;
  logic       iowe;
  logic       out_en;
  logic       ext_rst_n;
  logic       wdtmout;
  logic       core_rst_n;
  logic       rst_busy;

  int vectors     = 0;
  int miscompares = 0;

  logic       exp_core_q[$];
  logic [7:0] exp_mcusr_q[$];

  rstgen_mod #(
    .MCUSR_Address   (ADDR),
    .RST_HOLD_CYCLES (HOLD)
  ) dut (
    .cp2        (cp2),
    .ireset     (ireset),
    .adr        (adr),
    .dbus_in    (dbus_in),
    .dbus_out   (dbus_out),
    .iore       (iore),
    .iowe       (iowe),
    .out_en     (out_en),
    .ext_rst_n  (ext_rst_n),
    .wdtmout    (wdtmout),
    .core_rst_n (core_rst_n),
    .rst_busy   (rst_busy)
  );

  always #5 cp2 = ~cp2;

  task automatic tick();
    @(posedge cp2);
    #1;
  endtask

  // Software write of MCUSR in RUN; expected image queued with the write.
  task automatic test_write_value(input logic [7:0] data, input logic [7:0] expect_img);
    logic [7:0] e;
    exp_mcusr_q.push_back(expect_img);
    adr = ADDR; dbus_in = data; iowe = 1'b1;
    tick();
    iowe = 1'b0; dbus_in = 8'h00;
    e = exp_mcusr_q.pop_front();
    vectors++;
    if (dbus_out !== e || core_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL write_%h: mcusr=%h core=%b expected mcusr=%h core=1", data, dbus_out, core_rst_n, e);
    end
  endtask

  task automatic test_reset();
    logic e;
    ireset = 1'b1; ext_rst_n = 1'b1; wdtmout = 1'b0;
    iore = 1'b0; iowe = 1'b0; adr = 6'h00; dbus_in = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (core_rst_n !== 1'b0 || rst_busy !== 1'b1 || dbus_out !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_state: core=%b busy=%b mcusr=%h expected 0 1 01", core_rst_n, rst_busy, dbus_out);
    end
    ireset = 1'b0;
    for (int i = 1; i <= HOLD; i++) exp_core_q.push_back(i == HOLD);
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      e = exp_core_q.pop_front();
      vectors++;
      if (core_rst_n !== e || rst_busy !== ~e) begin
        miscompares++;
        $display("FAIL powerup_hold[%0d]: core=%b busy=%b expected core=%b", i, core_rst_n, rst_busy, e);
      end
    end
    vectors++;
    if (dbus_out !== 8'h01) begin
      miscompares++;
      $display("FAIL powerup_mcusr: got %h expected 01", dbus_out);
    end
  endtask

  task automatic test_out_en();
    logic [5:0] a_tab[4] = '{6'h34, 6'h35, 6'h34, 6'h00};
    logic       r_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       e_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      adr = a_tab[i]; iore = r_tab[i];
      #1;
      vectors++;
      if (out_en !== e_tab[i] || dbus_out !== 8'h01) begin
        miscompares++;
        $display("FAIL out_en[%0d]: out_en=%b dbus_out=%h expected %b 01", i, out_en, dbus_out, e_tab[i]);
      end
    end
    iore = 1'b0; adr = 6'h00;
  endtask

  task automatic test_watchdog();
    logic e;
    for (int i = 0; i <= HOLD; i++) exp_core_q.push_back(i == HOLD);
    wdtmout = 1'b1;
    for (int i = 0; i <= HOLD; i++) begin
      tick();
      wdtmout = 1'b0;
      e = exp_core_q.pop_front();
      vectors++;
      if (core_rst_n !== e || rst_busy !== ~e) begin
        miscompares++;
        $display("FAIL wdt_hold[%0d]: core=%b busy=%b expected core=%b", i, core_rst_n, rst_busy, e);
      end
    end
    vectors++;
    if (dbus_out !== 8'h09) begin
      miscompares++;
      $display("FAIL wdt_mcusr: got %h expected 09", dbus_out);
    end
  endtask

  task automatic test_write();
    logic       e;
    logic [7:0] em;
    test_write_value(8'hFF, 8'h09);
    test_write_value(8'hF6, 8'h00);
    // Clearing write coincides with a watchdog event: the set must survive.
    exp_mcusr_q.push_back(8'h08);
    adr = ADDR; dbus_in = 8'hF6; iowe = 1'b1; wdtmout = 1'b1;
    tick();
    iowe = 1'b0; wdtmout = 1'b0; dbus_in = 8'h00;
    em = exp_mcusr_q.pop_front();
    vectors++;
    if (dbus_out !== em || core_rst_n !== 1'b0) begin
      miscompares++;
      $display("FAIL write_vs_wdt: mcusr=%h core=%b expected %h 0", dbus_out, core_rst_n, em);
    end
    for (int i = 1; i <= HOLD; i++) exp_core_q.push_back(i == HOLD);
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      e = exp_core_q.pop_front();
      vectors++;
      if (core_rst_n !== e) begin
        miscompares++;
        $display("FAIL write_wdt_hold[%0d]: core=%b expected %b", i, core_rst_n, e);
      end
    end
  endtask

  task automatic test_ext_pin();
    logic e;
    test_write_value(8'h00, 8'h00);
    // Pin low for edges 0..39; reset seen at edge 2, released 16 cycles after sync rises.
    for (int i = 0; i <= 57; i++) exp_core_q.push_back(i < 2 || i == 57);
    for (int i = 0; i <= 57; i++) begin
      ext_rst_n = (i >= 40);
      tick();
      e = exp_core_q.pop_front();
      vectors++;
      if (core_rst_n !== e || rst_busy !== ~e) begin
        miscompares++;
        $display("FAIL ext_hold[%0d]: core=%b busy=%b expected core=%b", i, core_rst_n, rst_busy, e);
      end
    end
    vectors++;
    if (dbus_out !== 8'h02) begin
      miscompares++;
      $display("FAIL ext_mcusr: got %h expected 02", dbus_out);
    end
  endtask

  task automatic test_simultaneous();
    int  budget;
    test_write_value(8'h00, 8'h00);
    ext_rst_n = 1'b0;
    tick();
    tick();
    wdtmout = 1'b1;
    tick();
    wdtmout = 1'b0;
    vectors++;
    if (core_rst_n !== 1'b0 || dbus_out !== 8'h0A) begin
      miscompares++;
      $display("FAIL simultaneous: core=%b mcusr=%h expected 0 0a", core_rst_n, dbus_out);
    end
    ext_rst_n = 1'b1;
    budget = 0;
    while (core_rst_n !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    vectors++;
    if (core_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL simultaneous_release: core=%b after %0d cycles expected 1", core_rst_n, budget);
    end
  endtask

  task automatic test_ignored();
    logic e;
    test_write_value(8'h00, 8'h00);
    for (int i = 0; i <= HOLD; i++) exp_core_q.push_back(i == HOLD);
    wdtmout = 1'b1;
    for (int i = 0; i <= HOLD; i++) begin
      tick();
      wdtmout = (i == 4);
      iowe    = (i == 6);
      adr     = ADDR;
      dbus_in = 8'h00;
      e = exp_core_q.pop_front();
      vectors++;
      if (core_rst_n !== e) begin
        miscompares++;
        $display("FAIL ignored_hold[%0d]: core=%b expected %b", i, core_rst_n, e);
      end
    end
    wdtmout = 1'b0; iowe = 1'b0;
    vectors++;
    if (dbus_out !== 8'h08) begin
      miscompares++;
      $display("FAIL ignored_mcusr: got %h expected 08", dbus_out);
    end
  endtask

  task automatic test_ireset_mid_hold();
    logic e;
    wdtmout = 1'b1;
    tick();
    wdtmout = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ireset = 1'b1;
    tick();
    ireset = 1'b0;
    vectors++;
    if (core_rst_n !== 1'b0 || dbus_out !== 8'h01) begin
      miscompares++;
      $display("FAIL ireset_mid: core=%b mcusr=%h expected 0 01", core_rst_n, dbus_out);
    end
    for (int i = 1; i <= HOLD; i++) exp_core_q.push_back(i == HOLD);
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      e = exp_core_q.pop_front();
      vectors++;
      if (core_rst_n !== e) begin
        miscompares++;
        $display("FAIL ireset_mid_hold[%0d]: core=%b expected %b", i, core_rst_n, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_out_en();
    test_watchdog();
    test_write();
    test_ext_pin();
    test_simultaneous();
    test_ignored();
    test_ireset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
